mont_exp_ctrl: RTL and testbench

- Left-to-right square-and-multiply modular exponentiation sequencer.
- Acts as the initiator of the montgomery start/done handshake: it drives operands and one-cycle start pulses into a montgomery multiplier instance, waits for each done pulse, and captures each result.
- Computes in_x^in_e mod in_m entirely in the Montgomery domain, then performs a final multiply-by-1 to leave the domain.
- Sits between the top-level register interface and the montgomery core.

---
 rtl/mont_exp_ctrl.sv | 109 ++++++++++
 tb/tb_mont_exp_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply exponentiation sequencer driving a Montgomery
// multiplier over a start/done handshake; the result leaves the Montgomery domain.
module mont_exp_ctrl #(
  parameter int DATA_W = 1024,
  parameter int EXP_W  = 1024,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_r,
  input  logic [EXP_W-1:0]  in_e,
  input  logic [DATA_W-1:0] in_m,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              mont_start,
  output logic [DATA_W-1:0] mont_a,
  output logic [DATA_W-1:0] mont_b,
  output logic [DATA_W-1:0] mont_m,
  input  logic [DATA_W-1:0] mont_result,
  input  logic              mont_done
);

  typedef enum logic [3:0] {
    IDLE, SQ_ISSUE, SQ_WAIT, MUL_ISSUE, MUL_WAIT, NEXT, POST_ISSUE, POST_WAIT, DONE_ST
  } state_t;

  state_t             state;
  logic [DATA_W-1:0]  x_q, m_q, acc_q;
  logic [EXP_W-1:0]   e_q;
  logic [CNT_W-1:0]   cnt_q;

  assign mont_m = m_q;

  // mont_start is raised while leaving an ISSUE state, so it is high for the first
  // WAIT cycle only; the operands stay put until the next ISSUE state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      x_q        <= '0;
      e_q        <= '0;
      m_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      mont_start <= 1'b0;
      mont_a     <= '0;
      mont_b     <= '0;
    end else begin
      mont_start <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: if (start) begin
          x_q   <= in_x;
          e_q   <= in_e;
          m_q   <= in_m;
          acc_q <= in_r;
          cnt_q <= CNT_W'(EXP_W);
          busy  <= 1'b1;
          state <= SQ_ISSUE;
        end
        SQ_ISSUE: begin
          mont_start <= 1'b1;
          mont_a     <= acc_q;
          mont_b     <= acc_q;
          state      <= SQ_WAIT;
        end
        SQ_WAIT: if (mont_done) begin
          acc_q <= mont_result;
          state <= e_q[EXP_W-1] ? MUL_ISSUE : NEXT;
        end
        MUL_ISSUE: begin
          mont_start <= 1'b1;
          mont_a     <= acc_q;
          mont_b     <= x_q;
          state      <= MUL_WAIT;
        end
        MUL_WAIT: if (mont_done) begin
          acc_q <= mont_result;
          state <= NEXT;
        end
        NEXT: begin
          e_q   <= e_q << 1;
          cnt_q <= cnt_q - 1'b1;
          state <= (cnt_q == CNT_W'(1)) ? POST_ISSUE : SQ_ISSUE;
        end
        POST_ISSUE: begin
          mont_start <= 1'b1;
          mont_a     <= acc_q;
          mont_b     <= DATA_W'(1);
          state      <= POST_WAIT;
        end
        POST_WAIT: if (mont_done) begin
          result <= mont_result;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= DONE_ST;
        end
        DONE_ST: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: behavioural Montgomery multiplier with variable latency,
// reference x^e mod m computed with plain modular arithmetic.
module tb_mont_exp_ctrl;
  localparam int DW = 16;
  localparam int EW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [DW-1:0] in_x, in_r, in_m;
  logic [EW-1:0] in_e;
  logic          busy, done, mont_start;
  logic [DW-1:0] result, mont_a, mont_b, mont_m;
  logic [DW-1:0] mont_result;
  logic          mont_done;

  int checks = 0;
  int errors = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int stab_err = 0;
  int fixed_lat = 5;

  always #5 clk = ~clk;

  mont_exp_ctrl #(.DATA_W(DW), .EXP_W(EW), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .in_x(in_x), .in_r(in_r), .in_e(in_e),
    .in_m(in_m), .busy(busy), .done(done), .result(result), .mont_start(mont_start),
    .mont_a(mont_a), .mont_b(mont_b), .mont_m(mont_m), .mont_result(mont_result),
    .mont_done(mont_done)
  );

  // a*b*2^-16 mod m by halving modulo an odd m sixteen times
  function automatic logic [DW-1:0] mont_mul(input logic [DW-1:0] a, b, m);
    longint unsigned t;
    t = (longint'(a) * longint'(b)) % longint'(m);
    repeat (DW) begin
      if (t[0]) t = t + longint'(m);
      t = t >> 1;
    end
    return DW'(t);
  endfunction

  function automatic logic [DW-1:0] pow_mod(input logic [DW-1:0] x, input logic [EW-1:0] e,
                                            input logic [DW-1:0] m);
    longint unsigned r, b;
    r = 1 % longint'(m);
    b = longint'(x) % longint'(m);
    for (int i = 0; i < EW; i++) begin
      if (e[i]) r = (r * b) % longint'(m);
      b = (b * b) % longint'(m);
    end
    return DW'(r);
  endfunction

  // Multiplier model: operands captured on the start pulse, checked for stability
  // every cycle until the done pulse is delivered.
  logic          pending = 1'b0;
  int            lat_left;
  logic [DW-1:0] cap_a, cap_b, cap_m;
  always @(negedge clk) begin
    if (mont_start) start_cnt++;
    if (done) done_cnt++;
    if (mont_done) mont_done = 1'b0;
    if (pending) begin
      if (mont_a !== cap_a || mont_b !== cap_b) stab_err++;
      lat_left--;
      if (lat_left == 0) begin
        mont_result = mont_mul(cap_a, cap_b, cap_m);
        mont_done   = 1'b1;
        pending     = 1'b0;
      end
    end else if (mont_start) begin
      pending  = 1'b1;
      cap_a    = mont_a;
      cap_b    = mont_b;
      cap_m    = mont_m;
      lat_left = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(2, 40));
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // x is the base in normal form; the bench converts it and R into Montgomery form.
  task automatic run_op(input logic [DW-1:0] x, input logic [EW-1:0] e,
                        input logic [DW-1:0] m, input int lat, input int restart_at);
    logic [DW-1:0] exp_res;
    int  sbase, dbase;
    bit  seen, busy_drop;
    exp_res   = pow_mod(x, e, m);
    fixed_lat = lat;
    @(negedge clk);
    stab_err = 0;
    sbase    = start_cnt;
    dbase    = done_cnt;
    start = 1'b1;
    in_x  = DW'((longint'(x) << DW) % longint'(m));
    in_r  = DW'((64'd1 << DW) % longint'(m));
    in_e  = e;
    in_m  = m;
    @(negedge clk);
    start = 1'b0;
    in_x  = DW'($urandom); in_r = DW'($urandom); in_e = EW'($urandom); in_m = DW'($urandom);
    chk("busy_after_start", 64'(busy), 64'd1);
    seen = 0; busy_drop = 0;
    for (int cyc = 0; cyc < 6000 && !seen; cyc++) begin
      if (done) seen = 1;
      else begin
        if (!busy) busy_drop = 1;
        start = (cyc == restart_at);
        @(negedge clk);
        start = 1'b0;
      end
    end
    chk("done_within_bound", 64'(seen), 64'd1);
    chk("result", 64'(result), 64'(exp_res));
    chk("busy_low_at_done", 64'(busy), 64'd0);
    chk("mont_m_held", 64'(mont_m), 64'(m));
    chk("mont_start_pulses", 64'(start_cnt - sbase), 64'(EW + $countones(e) + 1));
    chk("busy_held_until_done", 64'(busy_drop), 64'd0);
    chk("operand_stability", 64'(stab_err), 64'd0);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("result_held", 64'(result), 64'(exp_res));
    chk("done_pulse_count", 64'(done_cnt - dbase), 64'd1);
  endtask

  initial begin
    logic [DW-1:0] rm, rx;
    int dsave;
    reset = 1'b1; start = 1'b0; mont_done = 1'b0; mont_result = '0;
    in_x = '0; in_r = '0; in_e = '0; in_m = '0;
    @(negedge clk); @(negedge clk);
    chk("reset_outputs", {busy, done, mont_start, result, mont_a, mont_b, mont_m}, 64'd0);
    reset = 1'b0;

    run_op(16'd3, 16'd5, 16'd13, 5, -1);
    run_op(16'd3, 16'd0, 16'd13, 5, -1);
    run_op(16'd2, 16'hFFFF, 16'd13, 5, -1);
    run_op(16'd3, 16'd5, 16'd13, 5, 7);
    run_op(16'd7, 16'hA5C3, 16'd13, 2, -1);
    run_op(16'd7, 16'hA5C3, 16'd13, 40, -1);

    // abort in the first SQ_WAIT, then let the pending mont_done arrive
    fixed_lat = 12;
    @(negedge clk);
    start = 1'b1; in_x = 16'd9; in_r = 16'd3; in_e = 16'd5; in_m = 16'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    dsave = done_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_outputs_zero", {busy, done, mont_start, result, mont_a, mont_b, mont_m}, 64'd0);
    chk("abort_no_done", 64'(done_cnt - dsave), 64'd0);
    run_op(16'd3, 16'd5, 16'd13, 5, -1);

    for (int k = 0; k < 6; k++) begin
      rm = DW'($urandom_range(3, 65535)) | 16'd1;
      rx = DW'($urandom % rm);
      run_op(rx, EW'($urandom), rm, 0, (k == 2) ? 3 : -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
